// File: rtl/als_sample_sequencer_if.sv
// Signal bundle between the ALS sample sequencer, the PMOD pins and the sample consumer.
// The slave modport is the sequencer's view; master is the driving/consuming side.
interface als_sample_sequencer_if;
  logic       i_enable;
  logic       i_start;
  logic       i_miso;
  logic       o_cs_n;
  logic       o_sclk;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;

  modport master (
    output i_enable,
    output i_start,
    output i_miso,
    input  o_cs_n,
    input  o_sclk,
    input  o_data,
    input  o_valid,
    input  o_busy
  );

  modport slave (
    input  i_enable,
    input  i_start,
    input  i_miso,
    output o_cs_n,
    output o_sclk,
    output o_data,
    output o_valid,
    output o_busy
  );
endinterface

// File: rtl/als_sample_sequencer.sv
// ADC081S021 (Digilent ALS PMOD) conversion sequencer: SPI clocking, chip-select and
// 8-bit sample extraction, triggered periodically or on demand.
module als_sample_sequencer #(
  parameter int unsigned HALF_PERIOD   = 25,
  parameter int unsigned SAMPLE_PERIOD = 100000
) (
  input logic                   i_clock,
  input logic                   i_aresetn,
  als_sample_sequencer_if.slave bus
);

  localparam int unsigned HalfW = $clog2(HALF_PERIOD);
  localparam int unsigned IntW  = $clog2(SAMPLE_PERIOD);

  localparam logic [HalfW-1:0] HalfLast   = HalfW'(HALF_PERIOD - 1);
  localparam logic [HalfW-1:0] HalfPenult = HalfW'(HALF_PERIOD - 2);
  localparam logic [IntW-1:0]  IntLast    = IntW'(SAMPLE_PERIOD - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StQuiet = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [HalfW-1:0] half_q, half_d;
  logic [3:0]       bit_q, bit_d;
  logic [IntW-1:0]  interval_q, interval_d;
  logic             pending_q, pending_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic [15:0]      shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;

  logic wrap;
  logic req;
  logic half_done;

  // Interval counter only runs while periodic sampling is enabled.
  always_comb begin
    interval_d = interval_q;
    wrap       = 1'b0;
    if (!bus.i_enable) begin
      interval_d = '0;
    end else if (interval_q == IntLast) begin
      interval_d = '0;
      wrap       = 1'b1;
    end else begin
      interval_d = interval_q + IntW'(1);
    end
  end

  assign req       = bus.i_start | wrap;
  assign half_done = (half_q == HalfLast);

  always_comb begin
    state_d   = state_q;
    half_d    = half_done ? '0 : half_q + HalfW'(1);
    bit_d     = bit_q;
    pending_d = pending_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    // Requests arriving while a frame is in flight collapse into one follow-up frame.
    if ((state_q != StIdle) && req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        half_d = '0;
        if (req || pending_q) begin
          state_d   = StSetup;
          cs_n_d    = 1'b0;
          pending_d = 1'b0;
          shift_d   = '0;
        end
      end
      StSetup: begin
        if (half_done) begin
          state_d = StShift;
          sclk_d  = 1'b0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (half_done) begin
          if (!sclk_q) begin
            // The ADC shifted this bit a full half-period ago on the falling edge.
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], bus.i_miso};
          end else if (bit_q == 4'd15) begin
            state_d = StHold;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end
      end
      StHold: begin
        // CS stays low one more half-period after the last SCLK rise.
        if (half_done) begin
          state_d = StQuiet;
          cs_n_d  = 1'b1;
        end
      end
      StQuiet: begin
        if (half_q == HalfPenult) begin
          valid_d = 1'b1;
          data_d  = shift_q[12:5];
        end
        if (half_done) begin
          state_d = StIdle;
          bit_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        half_d  = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q    <= StIdle;
      half_q     <= '0;
      bit_q      <= '0;
      interval_q <= '0;
      pending_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      interval_q <= interval_d;
      pending_q  <= pending_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_cs_n  = cs_n_q;
  assign bus.o_sclk  = sclk_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_als_sample_sequencer.sv
// Directed bench for als_sample_sequencer with a behavioural ADC081S021 and a pin monitor.
module tb_als_sample_sequencer;

  localparam int HP = 2;
  localparam int SP = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  als_sample_sequencer_if bus ();

  als_sample_sequencer #(
    .HALF_PERIOD  (HP),
    .SAMPLE_PERIOD(SP)
  ) dut (
    .i_clock  (clk),
    .i_aresetn(rst_n),
    .bus      (bus)
  );

  int passed = 0;
  int total  = 0;

  // ADC model: bit 15 appears on the first SCLK fall, one bit per fall after that.
  logic [15:0] adc_word;
  int          adc_idx = 15;
  always @(negedge bus.o_cs_n) adc_idx <= 15;
  always @(negedge bus.o_sclk) begin
    if (!bus.o_cs_n && adc_idx >= 0) begin
      bus.i_miso <= adc_word[adc_idx];
      adc_idx    <= adc_idx - 1;
    end
  end

  // Pin monitor, sampled mid-cycle.
  int   cyc = 0, rises = 0, bad_rises = 0, falls = 0, valids = 0;
  int   cs_len = 0, last_cs_len = 0, last_fall_cyc = 0, last_spacing = 0;
  int   last_rise_cyc = 0, last_valid_cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1;
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_cs   <= bus.o_cs_n;
    prev_sclk <= bus.o_sclk;
    if (!prev_sclk && bus.o_sclk) begin
      if (!bus.o_cs_n) rises <= rises + 1;
      else bad_rises <= bad_rises + 1;
    end
    if (prev_cs && !bus.o_cs_n) begin
      falls         <= falls + 1;
      last_spacing  <= cyc - last_fall_cyc;
      last_fall_cyc <= cyc;
      cs_len        <= 1;
      rises         <= 0;
    end else if (!bus.o_cs_n) begin
      cs_len <= cs_len + 1;
    end
    if (!prev_cs && bus.o_cs_n) begin
      last_cs_len   <= cs_len;
      last_rise_cyc <= cyc;
    end
    if (bus.o_valid) begin
      valids         <= valids + 1;
      last_valid_cyc <= cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    tick();
    while (!bus.o_valid && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.o_valid), 1);
  endtask

  task automatic wait_rises(input string tag, input int k);
    int n = 0;
    while (rises < k && n < 500) begin
      tick();
      n++;
    end
    check(tag, 32'(rises >= k), 1);
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    int f = falls;
    tick();
    while (falls == f && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(falls != f), 1);
  endtask

  function automatic logic [15:0] mk(input logic [7:0] v, input logic [4:0] t);
    return {3'b000, v, t};
  endfunction

  logic [7:0] pvals [3] = '{8'h00, 8'hFF, 8'h5A};
  logic [4:0] ptail [3] = '{5'h1F, 5'h00, 5'h15};
  int f0, v0, n;

  initial begin
    rst_n        = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_start  = 1'b0;
    adc_word     = '0;
    repeat (3) tick();
    check("rst_cs_n", 32'(bus.o_cs_n), 1);
    check("rst_sclk", 32'(bus.o_sclk), 1);
    check("rst_data", 32'(bus.o_data), 0);
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_pending", 32'(dut.pending_q), 0);
    rst_n = 1'b1;
    tick();

    // Single shot
    adc_word = mk(8'hB3, 5'h00);
    f0 = falls;
    v0 = valids;
    pulse_start();
    check("req_to_cs", 32'(bus.o_cs_n), 0);
    check("ss_busy", 32'(bus.o_busy), 1);
    wait_valid("ss_valid");
    check("ss_data", 32'(bus.o_data), 32'hB3);
    check("ss_rises", rises, 16);
    check("ss_cs_len", last_cs_len, 34 * HP);
    // Valid lands on the HP-th cycle counting the first cs_n-high cycle as the first.
    check("ss_cs_to_valid", last_valid_cyc - last_rise_cyc, HP - 1);
    check("ss_busy_at_valid", 32'(bus.o_busy), 1);
    tick();
    check("ss_valid_one_cycle", 32'(bus.o_valid), 0);
    check("ss_busy_drop", 32'(bus.o_busy), 0);
    repeat (300) tick();
    check("ss_frames", falls - f0, 1);
    check("ss_valids", valids - v0, 1);

    // Periodic
    bus.i_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adc_word = mk(pvals[k], ptail[k]);
      wait_valid("per_valid");
      check("per_data", 32'(bus.o_data), 32'(pvals[k]));
      if (k > 0) check("per_spacing", last_spacing, SP);
    end

    // Disable mid-frame
    adc_word = mk(8'h3C, 5'h0A);
    wait_fall("dis_fall");
    wait_rises("dis_bit8", 8);
    bus.i_enable = 1'b0;
    wait_valid("dis_valid");
    check("dis_data", 32'(bus.o_data), 32'h3C);
    check("dis_interval", 32'(dut.interval_q), 0);
    f0 = falls;
    repeat (450) tick();
    check("dis_no_more", falls - f0, 0);
    check("dis_pending", 32'(dut.pending_q), 0);

    // Requests during busy
    adc_word = mk(8'hC7, 5'h03);
    f0 = falls;
    v0 = valids;
    pulse_start();
    wait_rises("busy_bit4", 4);
    pulse_start();
    tick();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_valid("busy_valid1");
    check("busy_data1", 32'(bus.o_data), 32'hC7);
    adc_word = mk(8'h81, 5'h1B);
    wait_fall("busy_fall2");
    check("busy_restart", last_fall_cyc - last_valid_cyc, 2);
    wait_valid("busy_valid2");
    check("busy_data2", 32'(bus.o_data), 32'h81);
    repeat (300) tick();
    check("busy_frames", falls - f0, 2);
    check("busy_valids", valids - v0, 2);

    // Reset mid-frame
    adc_word = mk(8'h99, 5'h00);
    pulse_start();
    wait_rises("rstm_bit5", 5);
    v0 = valids;
    rst_n = 1'b0;
    #1;
    check("rstm_cs_n", 32'(bus.o_cs_n), 1);
    check("rstm_sclk", 32'(bus.o_sclk), 1);
    check("rstm_data", 32'(bus.o_data), 0);
    check("rstm_busy", 32'(bus.o_busy), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("rstm_no_valid", valids - v0, 0);
    adc_word = mk(8'h66, 5'h1F);
    pulse_start();
    wait_valid("rstm_valid");
    check("rstm_data_after", 32'(bus.o_data), 32'h66);
    check("rstm_rises", rises, 16);
    check("rstm_cs_len", last_cs_len, 34 * HP);

    // Coincident start and interval wrap
    repeat (5) tick();
    f0 = falls;
    v0 = valids;
    bus.i_enable = 1'b1;
    n = 0;
    while (dut.interval_q != 8'(SP - 1) && n < 400) begin
      tick();
      n++;
    end
    check("co_wrap_reached", 32'(dut.interval_q), SP - 1);
    bus.i_start = 1'b1;
    tick();
    bus.i_start  = 1'b0;
    bus.i_enable = 1'b0;
    check("co_cs", 32'(bus.o_cs_n), 0);
    check("co_pending_start", 32'(dut.pending_q), 0);
    wait_valid("co_valid");
    tick();
    check("co_pending_end", 32'(dut.pending_q), 0);
    repeat (300) tick();
    check("co_frames", falls - f0, 1);
    check("co_valids", valids - v0, 1);
    check("no_stray_sclk", bad_rises, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
